ccff_stream_loader: RTL and testbench
=====================================

// Module: ccff_stream_loader
// PURPOSE
//  Configuration-chain driver; sits directly upstream of the IO/logic tile ccff_head inputs.
//  Accepts bitstream words from the SoC-side host over a valid/ready port.
//  Serialises the words MSB-first onto ccff_head and raises a per-bit capture enable for the chain-clock ICG.
//  Optional verify pass compares the bitstream returning on ccff_tail against the bits being sent.
// PARAMETERS
//  WORD_W     32    width of host bitstream word
//  CHAIN_LEN  1024  total flops in the ccff chain; need not be a multiple of WORD_W
//  CNT_W      16    bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  prog_clk        in   1       configuration clock; all state on rising edge
//  prog_reset      in   1       async active-high reset
//  cfg_start       in   1       1-cycle pulse; starts a load, honoured only in IDLE/DONE
//  cfg_verify      in   1       sampled with cfg_start: 1 = load pass then verify pass
//  cfg_abort       in   1       synchronous abort, any state
//  cfg_word_data   in   WORD_W  bitstream word; bit WORD_W-1 is shifted first
//  cfg_word_valid  in   1       host word valid
//  cfg_word_ready  out  1       loader accepts word when valid&ready
//  ccff_head       out  1       serial data into chain
//  ccff_clk_en     out  1       chain captures ccff_head on the next prog_clk edge when 1
//  ccff_tail       in   1       serial data out of chain end
//  cfg_busy        out  1       high in LOAD/SHIFT
//  cfg_done        out  1       sticky; set on completion, cleared by cfg_start
//  cfg_error       out  1       sticky verify mismatch; cleared by cfg_start
//  cfg_bit_cnt     out  CNT_W   bits shifted in the current pass
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal shift register, counter, pass flag cleared.
//  Async reset mid-shift: outputs 0 immediately; chain contents undefined; host must restart.
//  FSM states: IDLE, LOAD, SHIFT, DONE.
//  IDLE/DONE + cfg_start: enter LOAD; cnt=0; pass=0; done=0; error=0; latch verify flag.
//  LOAD: cfg_word_ready=1. On valid&ready: capture word, bits_left=min(WORD_W, CHAIN_LEN-cnt), enter SHIFT.
//  SHIFT: cfg_word_ready=0, ccff_clk_en=1, ccff_head=shreg[WORD_W-1].
//   Each cycle: shreg<<=1, cnt++, bits_left--.
//  SHIFT bits_left reaches 0:
//   - cnt<CHAIN_LEN: return to LOAD.
//   - cnt==CHAIN_LEN, verify latched and pass==0: pass=1, cnt=0, enter LOAD.
//   - otherwise: enter DONE; done=1.
//  Rate: 1 bit/cycle plus 1 LOAD cycle per word minimum. Ready is never high in SHIFT, so no back-to-back accept.
//  Partial last word: when CHAIN_LEN mod WORD_W != 0, only the top (CHAIN_LEN mod WORD_W) bits are shifted; remaining bits dropped.
//  Verify (pass==1):
//   - Host re-sends the identical bitstream.
//   - In every SHIFT cycle ccff_tail must equal ccff_head; else error=1 (sticky).
//   - Shifting continues after a mismatch, so the chain ends holding the pass-1 data.
//  cfg_abort: next state IDLE; clk_en and ready drop next edge; done not set; error keeps its value. Abort wins over cfg_start.
//  cfg_start outside IDLE/DONE is ignored.
//  cfg_word_valid is ignored outside LOAD; the word is not consumed.
//  cfg_busy = (state==LOAD || state==SHIFT).
//  cfg_bit_cnt resets to 0 at the start of each pass.
//  All outputs are registered, no comb path input->output.
// TESTING
//  1. WORD_W=32, CHAIN_LEN=40, words 0xA5A5A5A5, 0xFF000000 -> exactly 40 clk_en cycles;
//     head stream = A5A5A5A5 then 8 ones; done=1; cnt=40; low 24 bits of word 2 never driven.
//  2. Verify on, chain model 40-flop shift reg, same 2 words sent twice
//     -> 80 clk_en cycles, error=0, done=1.
//  3. Verify on, flip one bit of word 1 on second send -> error=1 at that bit cycle, still 80 shifts, done=1.
//  4. Host stalls valid 5 cycles between words -> ready high 5+ cycles, clk_en low during stall, head stream unchanged.
//  5. cfg_abort at bit 17 -> IDLE next cycle, clk_en=0, busy=0, done=0.
//     Then cfg_start -> cnt restarts at 0.
//  6. prog_reset asserted mid-SHIFT, async -> all outputs 0 before the next edge.
//     cfg_start during SHIFT -> ignored, cnt continues.

Source files
------------

// File: rtl/ccff_stream_loader.sv
// Configuration-chain driver: takes host bitstream words over valid/ready and shifts
// them MSB-first onto ccff_head, with an optional read-back verify pass on ccff_tail.
module ccff_stream_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              cfg_start,
   input  logic              cfg_verify,
   input  logic              cfg_abort,
   input  logic [WORD_W-1:0] cfg_word_data,
   input  logic              cfg_word_valid,
   output logic              cfg_word_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_error,
   output logic [CNT_W-1:0]  cfg_bit_cnt,
   output logic [1:0]        dbg_state
);

   // Host port: a word transfers on a rising edge where cfg_word_valid and
   // cfg_word_ready are both 1; ready depends only on registered state, and the
   // host must hold data stable while valid is high and ready is low.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  bits_left_q, bits_left_d;
   logic              pass_q, pass_d;
   logic              verify_q, verify_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [CNT_W-1:0]  remaining;
   logic [CNT_W-1:0]  cnt_inc;

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         shreg_q     <= '0;
         cnt_q       <= '0;
         bits_left_q <= '0;
         pass_q      <= 1'b0;
         verify_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         bits_left_q <= bits_left_d;
         pass_q      <= pass_d;
         verify_q    <= verify_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      bits_left_d = bits_left_q;
      pass_d      = pass_q;
      verify_d    = verify_q;
      done_d      = done_q;
      error_d     = error_q;
      remaining   = CHAIN_LEN_C - cnt_q;
      cnt_inc     = cnt_q + CNT_ONE;

      // Abort freezes every register except the state, so done is not set and error holds.
      if (cfg_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (cfg_start) begin
                  state_d  = S_LOAD;
                  cnt_d    = '0;
                  pass_d   = 1'b0;
                  done_d   = 1'b0;
                  error_d  = 1'b0;
                  verify_d = cfg_verify;
               end
            end
            S_LOAD: begin
               if (cfg_word_valid) begin
                  shreg_d     = cfg_word_data;
                  bits_left_d = (remaining < WORD_W_C) ? remaining : WORD_W_C;
                  state_d     = S_SHIFT;
               end
            end
            S_SHIFT: begin
               shreg_d     = shreg_q << 1;
               cnt_d       = cnt_inc;
               bits_left_d = bits_left_q - CNT_ONE;
               // On the verify pass the chain end must replay what the load pass sent.
               if (pass_q && (ccff_tail != shreg_q[WORD_W-1])) begin
                  error_d = 1'b1;
               end
               if (bits_left_q == CNT_ONE) begin
                  if (cnt_inc < CHAIN_LEN_C) begin
                     state_d = S_LOAD;
                  end else if (verify_q && !pass_q) begin
                     pass_d  = 1'b1;
                     cnt_d   = '0;
                     state_d = S_LOAD;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; nothing passes combinationally from inputs.
   assign cfg_word_ready = (state_q == S_LOAD);
   assign ccff_clk_en    = (state_q == S_SHIFT);
   assign ccff_head      = (state_q == S_SHIFT) && shreg_q[WORD_W-1];
   assign cfg_busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign cfg_done       = done_q;
   assign cfg_error      = error_q;
   assign cfg_bit_cnt    = cnt_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: random bitstreams through a 40-flop chain model, with a
// scoreboard of expected head bits, bit indices and verify mismatches.
module tb_ccff_stream_loader;

   localparam int WORD_W    = 32;
   localparam int CHAIN_LEN = 40;
   localparam int CNT_W     = 16;
   localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

   logic              prog_clk = 1'b0;
   logic              prog_reset = 1'b1;
   logic              cfg_start = 1'b0;
   logic              cfg_verify = 1'b0;
   logic              cfg_abort = 1'b0;
   logic [WORD_W-1:0] cfg_word_data = '0;
   logic              cfg_word_valid = 1'b0;
   logic              cfg_word_ready;
   logic              ccff_head;
   logic              ccff_clk_en;
   logic              ccff_tail;
   logic              cfg_busy;
   logic              cfg_done;
   logic              cfg_error;
   logic [CNT_W-1:0]  cfg_bit_cnt;
   logic [1:0]        dbg_state;

   ccff_stream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(cfg_start),
      .cfg_verify(cfg_verify), .cfg_abort(cfg_abort), .cfg_word_data(cfg_word_data),
      .cfg_word_valid(cfg_word_valid), .cfg_word_ready(cfg_word_ready),
      .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
      .cfg_bit_cnt(cfg_bit_cnt), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 prog_clk = ~prog_clk;

   // Chain model: a plain shift register clocked by the gated enable.
   logic [CHAIN_LEN-1:0] chain = '0;
   always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   assign ccff_tail = chain[CHAIN_LEN-1];

   int n_checks = 0;
   int n_errors = 0;
   int shifts = 0;
   int shifts0 = 0;
   logic err_model = 1'b0;
   // item: [9] verify mismatch expected, [8] head bit, [7:0] bit index in pass
   logic [9:0] exp_q[$];
   logic [WORD_W-1:0] pw[2][N_WORDS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic sbit(input int p, input int i);
      logic [WORD_W-1:0] w;
      w = pw[p][i / WORD_W];
      return w[WORD_W-1 - (i % WORD_W)];
   endfunction

   // Monitor / scoreboard
   initial begin
      logic [9:0] item;
      forever begin
         @(negedge prog_clk);
         if (!prog_reset && ccff_clk_en) begin
            shifts++;
            if (exp_q.size() == 0) begin
               check("unexpected_shift", 32'(ccff_clk_en), 32'd0);
            end else begin
               item = exp_q.pop_front();
               check("head_bit", 32'(ccff_head), 32'(item[8]));
               check("bit_cnt", 32'(cfg_bit_cnt), 32'(item[7:0]));
               check("error_so_far", 32'(cfg_error), 32'(err_model));
               check("no_ready_in_shift", 32'(cfg_word_ready), 32'd0);
               err_model = err_model | item[9];
            end
         end
      end
   end

   // Driver tasks (all called and returning at a falling edge)
   task automatic wait_ready(input string name);
      int guard = 0;
      while (!cfg_word_ready && guard < 500) begin
         @(negedge prog_clk);
         guard++;
      end
      if (!cfg_word_ready) check(name, 32'(cfg_word_ready), 32'd1);
   endtask

   task automatic send_word(input int p, input int k);
      int lo = k * WORD_W;
      int hi = (lo + WORD_W < CHAIN_LEN) ? lo + WORD_W : CHAIN_LEN;
      cfg_word_data  = pw[p][k];
      cfg_word_valid = 1'b1;
      wait_ready("ready_timeout");
      for (int i = lo; i < hi; i++) begin
         logic mism;
         mism = (p == 1) && (sbit(0, i) != sbit(1, i));
         exp_q.push_back({mism, sbit(p, i), 8'(i)});
      end
      @(negedge prog_clk);
      cfg_word_valid = 1'b0;
      cfg_word_data  = $urandom();
   endtask

   task automatic send_pass(input int p, input int stall);
      for (int k = 0; k < N_WORDS; k++) begin
         if (k > 0 && stall > 0) begin
            wait_ready("stall_ready_timeout");
            repeat (stall) begin
               check("stall_ready", 32'(cfg_word_ready), 32'd1);
               check("stall_clk_en", 32'(ccff_clk_en), 32'd0);
               @(negedge prog_clk);
            end
         end
         send_word(p, k);
      end
   endtask

   task automatic do_start(input logic v);
      cfg_start  = 1'b1;
      cfg_verify = v;
      @(negedge prog_clk);
      cfg_start  = 1'b0;
      cfg_verify = $urandom_range(0, 1);
      exp_q.delete();
      err_model = 1'b0;
      shifts0   = shifts;
      check("start_state", {cfg_busy, cfg_word_ready, cfg_done, cfg_error, 28'(cfg_bit_cnt)},
            {1'b1, 1'b1, 1'b0, 1'b0, 28'd0});
   endtask

   task automatic finish_check(input int exp_shifts, input logic exp_err);
      int guard = 0;
      while (!cfg_done && guard < 500) begin
         @(negedge prog_clk);
         guard++;
      end
      check("done", 32'(cfg_done), 32'd1);
      check("busy_after_done", 32'(cfg_busy), 32'd0);
      check("final_cnt", 32'(cfg_bit_cnt), 32'(CHAIN_LEN));
      check("final_error", 32'(cfg_error), 32'(exp_err));
      check("shift_count", 32'(shifts - shifts0), 32'(exp_shifts));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_load(input logic v, input int stall);
      logic exp_err = 1'b0;
      if (v) for (int i = 0; i < CHAIN_LEN; i++) exp_err |= (sbit(0, i) != sbit(1, i));
      do_start(v);
      send_pass(0, stall);
      if (v) send_pass(1, stall);
      finish_check(v ? 2 * CHAIN_LEN : CHAIN_LEN, exp_err);
   endtask

   initial begin
      int c0;
      // reset state
      #12;
      check("reset_outputs",
            {ccff_head, ccff_clk_en, cfg_word_ready, cfg_busy, cfg_done, cfg_error, dbg_state, 16'(cfg_bit_cnt)},
            24'd0);
      @(negedge prog_clk);
      prog_reset = 1'b0;
      @(negedge prog_clk);

      // partial last word
      pw[0][0] = 32'hA5A5_A5A5; pw[0][1] = 32'hFF00_0000;
      pw[1] = pw[0];
      run_load(1'b0, 0);

      // verify pass, identical data
      run_load(1'b1, 0);

      // verify pass with one flipped bit in the first word
      pw[1][0] = pw[0][0] ^ 32'h0000_0400;
      run_load(1'b1, 0);

      // host stall between words
      pw[1] = pw[0];
      run_load(1'b0, 5);

      // randomized loads
      for (int r = 0; r < 8; r++) begin
         logic v;
         for (int k = 0; k < N_WORDS; k++) pw[0][k] = $urandom();
         pw[1] = pw[0];
         v = $urandom_range(0, 1);
         if (v && $urandom_range(0, 1)) begin
            int b = $urandom_range(0, CHAIN_LEN - 1);
            pw[1][b / WORD_W] = pw[1][b / WORD_W] ^ (32'h8000_0000 >> (b % WORD_W));
         end
         run_load(v, $urandom_range(0, 3));
      end

      // abort at bit 17, then restart
      do_start(1'b0);
      send_word(0, 0);
      begin
         int guard = 0;
         while (cfg_bit_cnt != 16'd17 && guard < 100) begin
            @(negedge prog_clk);
            guard++;
         end
         check("reach_bit17", 32'(cfg_bit_cnt), 32'd17);
      end
      cfg_abort = 1'b1;
      @(negedge prog_clk);
      cfg_abort = 1'b0;
      check("abort_outputs", {ccff_clk_en, cfg_busy, cfg_done, cfg_word_ready, dbg_state}, 6'd0);
      exp_q.delete();
      do_start(1'b0);
      send_pass(0, 0);
      finish_check(CHAIN_LEN, 1'b0);

      // start during shift is ignored
      do_start(1'b0);
      send_word(0, 0);
      repeat (3) @(negedge prog_clk);
      c0 = int'(cfg_bit_cnt);
      cfg_start = 1'b1;
      @(negedge prog_clk);
      cfg_start = 1'b0;
      check("start_ignored_cnt", 32'(cfg_bit_cnt), 32'(c0 + 1));
      check("start_ignored_shift", {30'd0, ccff_clk_en, cfg_busy}, 32'd3);
      send_word(0, 1);
      finish_check(CHAIN_LEN, 1'b0);

      // async reset mid-shift
      do_start(1'b0);
      send_word(0, 0);
      repeat (4) @(negedge prog_clk);
      #2 prog_reset = 1'b1;
      #1;
      check("async_reset_outputs",
            {ccff_head, ccff_clk_en, cfg_word_ready, cfg_busy, cfg_done, cfg_error, dbg_state, 16'(cfg_bit_cnt)},
            24'd0);
      @(negedge prog_clk);
      prog_reset = 1'b0;
      exp_q.delete();
      @(negedge prog_clk);
      pw[1] = pw[0];
      run_load(1'b1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
